// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store memory initiator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        FIN  = 2'd3
    } state_t;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Access size in bytes; illegal encodings report 4 and are caught by funct3_legal.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            3'd0, 3'd4: access_size = 3'd1;
            3'd1, 3'd5: access_size = 3'd2;
            default:    access_size = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            funct3_legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        else
            funct3_legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                           (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and write data for both word halves, plus load merge/extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: funct3/off/split/wdata describe the held request; mem_rd and lo_buf are the
//        read words; be_lo/wd_lo drive the first word, be_hi/wd_hi the second word,
//        load_data is the extended load result.
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        split,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rd,
    input  logic [31:0] lo_buf,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wd_lo,
    output logic [31:0] wd_hi,
    output logic [31:0] load_data
);

    logic [3:0]  mask;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [63:0] rd_wide;
    logic [31:0] load_raw;
    logic [4:0]  sh_bits;

    assign sh_bits = {off, 3'b000};
    assign mask    = size_mask(access_size(funct3));

    // Shifting across a 64-bit window gives both halves at once: the upper half
    // equals (x >> (4 - off)) which is exactly what the second word needs.
    assign be_wide = {4'b0000, mask} << off;
    assign wd_wide = {32'd0, wdata} << sh_bits;
    assign be_lo   = be_wide[3:0];
    assign be_hi   = be_wide[7:4];
    assign wd_lo   = wd_wide[31:0];
    assign wd_hi   = wd_wide[63:32];

    // For a split load, mem_rd holds the higher word and lo_buf the lower one.
    assign rd_wide  = split ? {mem_rd, lo_buf} : {32'd0, mem_rd};
    assign load_raw = 32'(rd_wide >> sh_bits);

    always_comb begin
        load_data = load_raw;
        case (funct3)
            F3_LB:   load_data = {{24{load_raw[7]}}, load_raw[7:0]};
            F3_LH:   load_data = {{16{load_raw[15]}}, load_raw[15:0]};
            F3_LBU:  load_data = {24'd0, load_raw[7:0]};
            F3_LHU:  load_data = {16'd0, load_raw[15:0]};
            default: load_data = load_raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator to a 1-cycle registered data memory; splits word-crossing accesses.
// Latency: accept->resp_valid is 2 edges aligned, 3 split, 1 for rejected requests.
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle pulse with no backpressure.
// Ports: clk/reset; req_* request from execute; resp_* completion; mem_* memory port
//        (mem_* outputs are decoded from state and idle at zero), mem_rd read data.
import lsu_pkg::*;

module lsu_mem_initiator #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] lo_buf_q, lo_buf_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        req_split;
    logic        req_bad;
    logic        split_r;
    logic [31:0] word0;
    logic [31:0] word1;
    logic [3:0]  be_lo, be_hi;
    logic [31:0] wd_lo, wd_hi;
    logic [31:0] load_data;

    // off (0..3) + size (1,2,4) never exceeds 7, so 3 bits hold the sum.
    assign req_split = ({1'b0, req_addr[1:0]} + access_size(req_funct3)) > 3'd4;
    assign req_bad   = !funct3_legal(req_we, req_funct3) ||
                       (req_split && !ALLOW_MISALIGNED);

    assign split_r = ({1'b0, addr_q[1:0]} + access_size(funct3_q)) > 3'd4;
    assign word0   = {addr_q[31:2], 2'b00};
    assign word1   = word0 + 32'd4;   // wraps 0xFFFFFFFC -> 0

    lsu_align u_align (
        .funct3    (funct3_q),
        .off       (addr_q[1:0]),
        .split     (split_r),
        .wdata     (wdata_q),
        .mem_rd    (mem_rd),
        .lo_buf    (lo_buf_q),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .wd_lo     (wd_lo),
        .wd_hi     (wd_hi),
        .load_data (load_data)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        lo_buf_d     = lo_buf_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        req_ready    = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'd0;
        mem_a        = 32'd0;
        mem_wd       = 32'd0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_bad;
                    state_d  = req_bad ? FIN : ACC0;
                end
            end
            ACC0: begin
                mem_a   = word0;
                mem_be  = be_lo;
                mem_wd  = wd_lo;
                mem_we  = we_q;
                state_d = split_r ? ACC1 : FIN;
            end
            ACC1: begin
                mem_a    = word1;
                mem_be   = be_hi;
                mem_wd   = wd_hi;
                mem_we   = we_q;
                lo_buf_d = mem_rd;   // word0 read data arrives this cycle
                state_d  = FIN;
            end
            FIN: begin
                // No access was made for a rejected request, so there is no address to hold.
                if (!err_q)
                    mem_a = split_r ? word1 : word0;
                resp_valid_d = 1'b1;
                resp_err_d   = err_q;
                resp_rdata_d = (err_q || we_q) ? 32'd0 : load_data;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            lo_buf_q     <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            lo_buf_q     <= lo_buf_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator driving the data-memory port: word-aligned address, byte-lane enables, write data and write strobe.
- Accepts one load/store request at a time from the execute stage.
- Handles the memory's 1-cycle registered read latency.
- Splits misaligned accesses that cross a word boundary into two word accesses, merges the read lanes, and sign- or zero-extends load data.
- Sits between the core's MEM stage and the data memory.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split boundary-crossing accesses; 0 = reject them with resp_err and make no memory access.

Ports:
- clk  in  1  clock; memory samples on the same rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high exactly when state is IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_err  out  1  qualifies resp_valid; bad funct3 or rejected misalignment
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_we  out  1  memory write strobe
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_a  out  32  word address, bits [1:0] always 0
- mem_wd  out  32  lane-aligned write data
- mem_rd  in  32  memory read data, valid the cycle after the address edge

Behaviour:
- Clock and reset: single clock; reset asynchronous, active-high.
- Reset values:
  - state = IDLE.
  - resp_valid, resp_err, resp_rdata = 0.
  - mem_we, mem_be, mem_a, mem_wd = 0 (combinational from state; 0 in IDLE).
- Reset mid-access: abandon the access with no response; mem_we drops immediately.
- Request capture: req_valid && req_ready at edge E0 latches we, funct3, addr and wdata.
- Decode:
  - off = addr[1:0].
  - size = 1/2/4 bytes for funct3 0,4 / 1,5 / 2.
  - Legal loads: funct3 0, 1, 2, 4, 5. Legal stores: funct3 0, 1, 2.
  - split = off + size > 4.
- States:
  - IDLE: accept request. Illegal funct3, or split with ALLOW_MISALIGNED = 0, goes to FIN with err set; otherwise goes to ACC0.
  - ACC0:
    - mem_a = {addr[31:2], 2'b00}.
    - mem_be = (size mask << off)[3:0].
    - mem_wd = wdata << 8*off.
    - mem_we = we.
    - Goes to ACC1 if split, else FIN.
  - ACC1:
    - mem_a = word0 + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
    - mem_be = size mask >> (4 - off).
    - mem_wd = wdata >> 8*(4 - off).
    - mem_we = we.
    - Captures mem_rd (word0) into lo_buf at the edge, then goes to FIN.
  - FIN:
    - mem_we = 0, mem_be = 0; mem_a holds the last address.
    - mem_rd is the last word read.
    - At the edge: resp_valid <= 1, resp_err <= err, resp_rdata <= result; then go to IDLE.
- Load result:
  - Non-split: mem_rd >> 8*off.
  - Split: {mem_rd, lo_buf} >> 8*off, low 32 bits taken.
  - Then truncate to size and extend: funct3 0/1 sign-extend, 4/5 zero-extend, 2 pass through.
- Latency, counted as edges from E0 to the edge that raises resp_valid:
  - Aligned: 2.
  - Split: 3.
  - Error: 1.
- Store writes occur at the ACC0 edge (and the ACC1 edge when split).
- resp_valid is high for exactly one cycle, coincident with IDLE, so req_ready is also high that cycle. A new request accepted in that cycle is legal (back-to-back).
- Loads never assert mem_we. The lane math above is the same for loads and stores; only mem_we differs.

Decomposition:
- lsu_pkg:
  - state enum {IDLE, ACC0, ACC1, FIN}.
  - funct3 constants: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
  - size-mask function.
- lsu_align: one combinational sub-module holding the lane shifts, byte enables and load extension.
- lsu_mem_initiator: holds the FSM, request registers and lo_buf.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> one ACC0 cycle: mem_a 0x10, mem_be 4'b1111, mem_we 1. resp_valid 2 edges after accept, rdata 0.
- SB addr 0x13, wdata 0xAB -> mem_be 4'b1000, mem_wd 0xAB000000. Then LB 0x13 -> resp_rdata 0xFFFFFFAB; LBU 0x13 -> 0x000000AB.
- SW addr 0x0E, data 0x11223344, memory initially zero:
  - ACC0: mem_a 0x0C, be 4'b1100, wd 0x33440000.
  - ACC1: mem_a 0x10, be 4'b0011, wd 0x00001122.
  - LW 0x0E then returns 0x11223344 after 3 edges.
- LH addr 0xFFFFFFFF with word 0xFFFFFFFC = 0x80000000, word 0 = 0x00000001 -> ACC1 mem_a 0x00000000; resp_rdata 0x00000180.
- LH 0x0E with ALLOW_MISALIGNED = 1 completes via one access (no split). Loads with funct3 3 and 6, and a split LW with ALLOW_MISALIGNED = 0, each give resp_err 1 after 1 edge, mem_we never asserted, mem_be 0 throughout.
- Assert reset during ACC1 of a split store -> mem_we 0 immediately, no resp_valid, req_ready 1 after release; the word1 write has not happened.
